// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
// Holds the FSM encoding and the default operand width.
package serial_add_sub_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_sub_ctrl_fadder.sv
// One-bit full adder from two half adders and an OR; purely combinational.
// Zero latency, no flow control.
module hadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fadder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  logic s0;
  logic c0;
  logic c1;

  hadder u_ha0 (.a(A),  .b(B),   .s(s0), .c(c0));
  hadder u_ha1 (.a(s0), .b(Cin), .s(S),  .c(c1));

  assign Cout = c0 | c1;
endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial add/subtract, LSB first through one shared full adder; done pulses WIDTH+1 cycles
// after start is accepted. start is only accepted in IDLE and is dropped otherwise (no queuing).
module serial_add_sub_ctrl
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fa_s;
  logic fa_co;

  fadder u_fadder (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtract is A + ~B + 1: the +1 enters as the initial carry.
          a_d     = a;
          b_d     = op ? ~b : b;
          carry_d = op;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB.
          result_d = {fa_s, acc_q[WIDTH-1:1]};
          cout_d   = fa_co;
          ovf_d    = carry_q ^ fa_co;
          state_d  = DONE;
          done_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Bench for serial_add_sub_ctrl: directed corner cases plus random operations
// checked against an integer-arithmetic reference model.
module tb_serial_add_sub_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int tests;
  int fails;

  int last_r;
  int last_c;
  int last_v;

  serial_add_sub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int r, output int c, output int v);
    int ua, ub, sum, sa, sb, sr;
    ua  = int'(av);
    ub  = int'(bv);
    sum = o ? (ua + ((2**W - 1) - ub) + 1) : (ua + ub);
    r   = sum % (2**W);
    c   = (sum >= 2**W) ? 1 : 0;
    sa  = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb  = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    sr  = o ? (sa - sb) : (sa + sb);
    v   = (sr > 2**(W-1) - 1 || sr < -(2**(W-1))) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with cycle-exact checks; optionally scrambles inputs during RUN.
  task automatic do_op(input string tag, input logic o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input bit perturb);
    int er, ec, ev;
    model(o, av, bv, er, ec, ev);
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0;
    check({tag, ".busy_e0"}, busy, 1);
    check({tag, ".done_e0"}, done, 0);
    for (int k = 1; k <= W; k++) begin
      if (perturb) begin
        a     = W'($urandom);
        b     = W'($urandom);
        op    = 1'($urandom);
        start = 1'($urandom);
      end
      tick();
      if (k < W) begin
        check({tag, ".busy_run"}, busy, 1);
        check({tag, ".done_run"}, done, 0);
        check({tag, ".result_hold"}, result, last_r);
        check({tag, ".cout_hold"}, cout, last_c);
      end else begin
        check({tag, ".done"}, done, 1);
        check({tag, ".busy_done"}, busy, 0);
        check({tag, ".result"}, result, er);
        check({tag, ".cout"}, cout, ec);
        check({tag, ".ovf"}, ovf, ev);
      end
    end
    start = 1'b0;
    tick();
    check({tag, ".done_clr"}, done, 0);
    check({tag, ".busy_idle"}, busy, 0);
    check({tag, ".result_keep"}, result, er);
    last_r = er; last_c = ec; last_v = ev;
  endtask

  initial begin
    int d_cyc[$];
    int cyc;
    int n_done;
    bit found;
    logic [W-1:0] ra, rb;
    logic         ro;

    tests = 0; fails = 0;
    last_r = 0; last_c = 0; last_v = 0;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.result", result, 0);
    check("rst.cout", cout, 0);
    check("rst.ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    do_op("add_7_1",   1'b0, 4'd7,     4'd1, 1'b0);
    check("add_7_1.exp", result, 4'b1000);
    do_op("sub_5_3",   1'b1, 4'd5,     4'd3, 1'b0);
    check("sub_5_3.exp", result, 4'b0010);
    do_op("sub_8_1",   1'b1, 4'b1000,  4'd1, 1'b0);
    check("sub_8_1.ovf_exp", ovf, 1);
    do_op("sub_0_1",   1'b1, 4'd0,     4'd1, 1'b0);
    check("sub_0_1.exp", result, 4'b1111);
    do_op("add_15_1",  1'b0, 4'b1111,  4'd1, 1'b0);
    check("add_15_1.cout_exp", cout, 1);

    // start held high: accepted only from IDLE, done pulses WIDTH+2 apart
    start = 1'b1; op = 1'b0; a = 4'd3; b = 4'd2;
    cyc = 0;
    while (d_cyc.size() < 3 && cyc < 40) begin
      tick();
      cyc++;
      if (done) d_cyc.push_back(cyc);
    end
    start = 1'b0;
    check("hold.pulses", d_cyc.size(), 3);
    if (d_cyc.size() == 3) begin
      check("hold.first", d_cyc[0], W + 1);
      check("hold.gap1", d_cyc[1] - d_cyc[0], W + 2);
      check("hold.gap2", d_cyc[2] - d_cyc[1], W + 2);
    end
    check("hold.result", result, 5);
    tick();
    check("hold.idle", busy, 0);
    last_r = 5; last_c = 0; last_v = 0;

    do_op("perturb", 1'b1, 4'd9, 4'd12, 1'b1);

    // reset on the third RUN cycle aborts the operation
    start = 1'b1; op = 1'b0; a = 4'd7; b = 4'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort.busy_pre", busy, 1);
    rst_n = 1'b0;
    tick();
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.result", result, 0);
    check("abort.cout", cout, 0);
    check("abort.ovf", ovf, 0);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort.no_done", n_done, 0);
    last_r = 0; last_c = 0; last_v = 0;

    // start on the first edge after reset release is honoured
    rst_n = 1'b0; start = 1'b1; op = 1'b1; a = 4'd5; b = 4'd3;
    tick();
    check("rel.busy_in_rst", busy, 0);
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    check("rel.busy", busy, 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (done) found = 1'b1;
    end
    check("rel.done_seen", found, 1);
    check("rel.result", result, 2);
    check("rel.cout", cout, 1);
    tick();
    last_r = 2; last_c = 1; last_v = 0;

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ro = 1'($urandom);
      do_op("rand", ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_add_sub_ctrl.md
SERIAL_ADD_SUB_CTRL -- requirements
Module: serial_add_sub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, the request to begin an operation.
REQ-005 The block SHALL have port op, input, 1 bit: 0 = add (A+B), 1 = subtract (A-B).
REQ-006 The block SHALL have ports a and b, inputs, WIDTH bits each, the operands; they are sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit, high while bits are being processed.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking result valid.
REQ-009 The block SHALL have port result, output, WIDTH bits, the sum or difference.
REQ-010 The block SHALL have port cout, output, 1 bit, the raw carry out of the MSB (for subtract, 1 = no borrow).
REQ-011 The block SHALL have port ovf, output, 1 bit, signed two's-complement overflow.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at a clock edge SHALL latch a, b (b inverted when op=1), set the carry register to op, clear the bit counter, and move the FSM to RUN.
REQ-014 In RUN, each edge SHALL process exactly one bit, LSB first: a 1-bit full-add of the current a bit, b bit and carry, storing the sum bit in the result shift register and updating the carry.
REQ-015 On the edge that processes bit WIDTH-1, the block SHALL set cout to the final carry, set ovf to the carry into the MSB XOR the carry out of the MSB, update result, and move the FSM to DONE.
REQ-016 Latency SHALL be fixed: if start is accepted at edge E0, done SHALL be high for exactly the cycle following edge E(WIDTH).
REQ-017 busy SHALL be 1 exactly while the FSM is in RUN; done SHALL be 1 exactly while the FSM is in DONE.
REQ-018 From DONE, the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-019 start SHALL be ignored in RUN and DONE, with no queuing, and operand changes during RUN SHALL have no effect.
REQ-020 result, cout and ovf SHALL hold their last values from DONE until the next operation completes.
REQ-021 These outputs SHALL not change during RUN: bits accumulate in an internal register and are transferred to the outputs at completion.
REQ-022 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap during RUN; the terminal count is WIDTH-1.

Reset
REQ-023 When rst_n=0 at a clock edge, the block SHALL set the FSM to IDLE and clear busy, done, result, cout, ovf, the counter and all internal registers, regardless of state.
REQ-024 A reset asserted during RUN SHALL abort the operation with no done pulse, and start SHALL be honoured on the first edge with rst_n=1.

Structure
REQ-025 The FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default SHALL be defined in a shared package/header, serial_add_sub_pkg.
REQ-026 The per-bit cell SHALL be one sub-module, fadder (inputs A, B, Cin; outputs S, Cout), built from two hadder instances plus an OR gate.
REQ-027 The controller SHALL instantiate fadder exactly once and time-share it across all bit positions.

Verification
REQ-028 The bench SHALL cover: op=0, a=4'd7, b=4'd1 -> result=4'b1000, cout=0, ovf=1, done high exactly 5 cycles after the start edge.
REQ-029 The bench SHALL cover: op=1, a=4'd5, b=4'd3 -> result=4'b0010, cout=1, ovf=0.
REQ-030 The bench SHALL cover: op=1, a=4'b1000, b=4'd1 -> result=4'b0111, cout=1, ovf=1; and op=1, a=0, b=1 -> result=4'b1111, cout=0, ovf=0.
REQ-031 The bench SHALL cover: op=0, a=4'b1111, b=4'd1 -> result=0, cout=1, ovf=0; and with start held high continuously -> a new operation is accepted only in IDLE, with done pulses spaced WIDTH+2 cycles apart.
REQ-032 The bench SHALL cover: rst_n=0 on the third RUN cycle -> next cycle busy=0, done=0, result=0, and no done pulse follows.
REQ-033 The bench SHALL cover: toggling a and b and pulsing start during RUN -> result matches the operands captured at the accepted start.
